// File: rtl/ram_timing_model.sv
// ram_timing_model: word-addressed 32-bit RAM with a programmable access latency.
// It sits downstream of memory_control. The ramstate register (FREE/BUSY/ACCESS/ERROR)
// is both the FSM state and the status output, so no input reaches it combinationally.
// Optional feature: define RAM_STATS_EN to add the rd_count/wr_count completion counters.
module ram_timing_model #(
   parameter int ADDR_W = 10,
   parameter int LAT    = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] ramaddr,
   input  logic        ramREN,
   input  logic        ramWEN,
   input  logic [31:0] ramstore,
   output logic [31:0] ramload,
`ifdef RAM_STATS_EN
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
`endif
   output logic [1:0]  ramstate
);

   // Handshake: the requester asserts ramREN or ramWEN (level) with a stable ramaddr and
   // holds it until it sees ACCESS. ACCESS lasts one cycle and completes the transaction.
   // Write data and ramWEN are sampled at the edge leaving ACCESS. Read data is registered
   // on the edge entering ACCESS. A request still held at the leaving edge starts a new
   // transaction.
   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_ERROR  = 2'd3
   } ramstate_t;

   localparam int         DEPTH  = 1 << ADDR_W;
   localparam logic [3:0] LAT_M1 = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

   ramstate_t         state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic              op_q, op_d;        // 1 = write, 0 = read
   logic [31:0]       load_q, load_d;
   logic [31:0]       mem_q [DEPTH];

   logic              req;
   logic              illegal;
   logic              differs;
   logic              enter_access;
   logic              wr_en;
   logic [ADDR_W-1:0] req_idx;
   logic [ADDR_W-1:0] cap_idx;

   assign req     = ramREN | ramWEN;
   assign illegal = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00)
                  | ((ramaddr >> (ADDR_W + 2)) != 32'd0);
   assign differs = (ramaddr != addr_q) | (ramWEN != op_q);
   assign req_idx = ramaddr[ADDR_W+1:2];
   assign cap_idx = addr_q[ADDR_W+1:2];
   // Write commits only at the edge leaving ACCESS, and only if the writer still holds ramWEN.
   assign wr_en   = (state_q == ST_ACCESS) & op_q & ramWEN;

   assign ramload  = load_q;
   assign ramstate = state_q;

   // Next-state, latency counter, request capture and read-data load.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      op_d         = op_q;
      load_d       = load_q;
      enter_access = 1'b0;
      case (state_q)
         ST_BUSY: begin
            if (!req) begin
               state_d = ST_FREE;              // abort, nothing written
            end else if (differs) begin
               addr_d = ramaddr;               // requester changed its mind: restart latency
               op_d   = ramWEN;
               cnt_d  = LAT_M1;
            end else if (illegal) begin
               state_d = ST_ERROR;
            end else if (cnt_q == 4'd0) begin
               state_d      = ST_ACCESS;
               enter_access = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin                        // FREE, ACCESS and ERROR share the idle rules
            if (!req) begin
               state_d = ST_FREE;
            end else if (illegal) begin
               state_d = ST_ERROR;
            end else begin
               addr_d = ramaddr;
               op_d   = ramWEN;
               cnt_d  = LAT_M1;
               if (LAT == 0) begin
                  state_d      = ST_ACCESS;
                  enter_access = 1'b1;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
      endcase
      // Address is stable whenever ACCESS is entered, so the live index is the captured one.
      if (enter_access && !op_d) begin
         load_d = mem_q[req_idx];
      end
   end

   // Control registers with asynchronous reset; reset discards any open transaction.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_FREE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         op_q    <= 1'b0;
         load_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         load_q  <= load_d;
      end
   end

   // Storage array: never reset, written only when a write completes.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[cap_idx] <= ramstore;
      end
   end

`ifdef RAM_STATS_EN
   logic [31:0] rd_count_q, rd_count_d;
   logic [31:0] wr_count_q, wr_count_d;

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;

   // Count transactions completed at the edge leaving ACCESS (wraps naturally).
   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (state_q == ST_ACCESS) begin
         if (op_q) begin
            wr_count_d = wr_count_q + 32'd1;
         end else begin
            rd_count_d = rd_count_q + 32'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_count_q <= 32'd0;
         wr_count_q <= 32'd0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end
`endif

endmodule

// File: tb/tb_ram_timing_model.sv
// tb_ram_timing_model: directed vector table driving three instances of ram_timing_model
// (LAT=2, LAT=3, LAT=0). Each vector drives one instance for one cycle and then checks
// ramstate and, optionally, ramload. An async-reset sequence is written out by hand.
module tb_ram_timing_model;

   localparam logic [1:0] S_FREE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   typedef struct {
      int unsigned k;        // instance: 0 = LAT2, 1 = LAT3, 2 = LAT0
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] store;
      logic [1:0]  st;       // expected ramstate after the edge
      logic        cl;       // check ramload as well
      logic [31:0] ld;       // expected ramload
   } vec_t;

   logic        clk;
   logic        rst;
   logic        ren_a   [3];
   logic        wen_a   [3];
   logic [31:0] addr_a  [3];
   logic [31:0] store_a [3];
   logic [31:0] load_a  [3];
   logic [1:0]  state_a [3];
`ifdef RAM_STATS_EN
   logic [31:0] rdc_a   [3];
   logic [31:0] wrc_a   [3];
`endif

   int   checks   = 0;
   int   failures = 0;
   vec_t vecs[$];
   int   n1;

   // Clock and reset.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   ram_timing_model #(.ADDR_W(10), .LAT(2)) u_lat2 (
      .CLK(clk), .RST(rst), .ramaddr(addr_a[0]), .ramREN(ren_a[0]), .ramWEN(wen_a[0]),
      .ramstore(store_a[0]), .ramload(load_a[0]),
`ifdef RAM_STATS_EN
      .rd_count(rdc_a[0]), .wr_count(wrc_a[0]),
`endif
      .ramstate(state_a[0])
   );

   ram_timing_model #(.ADDR_W(10), .LAT(3)) u_lat3 (
      .CLK(clk), .RST(rst), .ramaddr(addr_a[1]), .ramREN(ren_a[1]), .ramWEN(wen_a[1]),
      .ramstore(store_a[1]), .ramload(load_a[1]),
`ifdef RAM_STATS_EN
      .rd_count(rdc_a[1]), .wr_count(wrc_a[1]),
`endif
      .ramstate(state_a[1])
   );

   ram_timing_model #(.ADDR_W(10), .LAT(0)) u_lat0 (
      .CLK(clk), .RST(rst), .ramaddr(addr_a[2]), .ramREN(ren_a[2]), .ramWEN(wen_a[2]),
      .ramstore(store_a[2]), .ramload(load_a[2]),
`ifdef RAM_STATS_EN
      .rd_count(rdc_a[2]), .wr_count(wrc_a[2]),
`endif
      .ramstate(state_a[2])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(int unsigned k, logic ren, logic wen, logic [31:0] addr,
                               logic [31:0] store, logic [1:0] st, logic cl, logic [31:0] ld);
      vec_t t;
      t.k = k; t.ren = ren; t.wen = wen; t.addr = addr; t.store = store;
      t.st = st; t.cl = cl; t.ld = ld;
      return t;
   endfunction

   function automatic void wr(int unsigned k, logic [31:0] a, logic [31:0] d, logic [1:0] st);
      vecs.push_back(mk(k, 1'b0, 1'b1, a, d, st, 1'b0, 32'd0));
   endfunction

   function automatic void rd(int unsigned k, logic [31:0] a, logic [1:0] st);
      vecs.push_back(mk(k, 1'b1, 1'b0, a, 32'd0, st, 1'b0, 32'd0));
   endfunction

   function automatic void rdl(int unsigned k, logic [31:0] a, logic [1:0] st, logic [31:0] ld);
      vecs.push_back(mk(k, 1'b1, 1'b0, a, 32'd0, st, 1'b1, ld));
   endfunction

   function automatic void idl(int unsigned k, logic [1:0] st);
      vecs.push_back(mk(k, 1'b0, 1'b0, 32'd0, 32'd0, st, 1'b0, 32'd0));
   endfunction

   // Drive one vector for one cycle, then compare.
   task automatic apply_vec(input int idx, input vec_t t);
      for (int i = 0; i < 3; i++) begin
         ren_a[i] = 1'b0;
         wen_a[i] = 1'b0;
      end
      ren_a[t.k]   = t.ren;
      wen_a[t.k]   = t.wen;
      addr_a[t.k]  = t.addr;
      store_a[t.k] = t.store;
      tick();
      chk($sformatf("v%0d_state", idx), 32'(state_a[t.k]), 32'(t.st));
      if (t.cl) chk($sformatf("v%0d_load", idx), load_a[t.k], t.ld);
   endtask

   initial begin
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ren_a[i] = 1'b0; wen_a[i] = 1'b0; addr_a[i] = 32'd0; store_a[i] = 32'd0;
      end

      // Scenario 1 (LAT2): write DEADBEEF to 0x40 then read it back.
      for (int i = 0; i < 2; i++) wr(0, 32'h40, 32'hDEADBEEF, S_BUSY);
      wr(0, 32'h40, 32'hDEADBEEF, S_ACC);
      wr(0, 32'h40, 32'hDEADBEEF, S_BUSY);   // still held at leaving edge: write commits, new txn
      idl(0, S_FREE);                         // new txn aborted
      rd(0, 32'h40, S_BUSY);
      rd(0, 32'h40, S_BUSY);
      rdl(0, 32'h40, S_ACC, 32'hDEADBEEF);
      idl(0, S_FREE);
      n1 = vecs.size();

      // Scenario 2 (LAT2): preload 0x44, then read 0x40 switching to 0x44 after one BUSY.
      for (int i = 0; i < 2; i++) wr(0, 32'h44, 32'h12345678, S_BUSY);
      wr(0, 32'h44, 32'h12345678, S_ACC);
      wr(0, 32'h44, 32'h12345678, S_BUSY);
      idl(0, S_FREE);
      rd(0, 32'h40, S_BUSY);
      rd(0, 32'h44, S_BUSY);                  // restart
      rd(0, 32'h44, S_BUSY);
      rdl(0, 32'h44, S_ACC, 32'h12345678);
      idl(0, S_FREE);

      // Scenario 3 (LAT3): known data, aborted write of 0x80 leaves old value.
      for (int i = 0; i < 3; i++) wr(1, 32'h84, 32'hCAFEF00D, S_BUSY);
      wr(1, 32'h84, 32'hCAFEF00D, S_ACC);
      wr(1, 32'h84, 32'hCAFEF00D, S_BUSY);
      idl(1, S_FREE);
      for (int i = 0; i < 3; i++) rd(1, 32'h84, S_BUSY);
      rdl(1, 32'h84, S_ACC, 32'hCAFEF00D);
      idl(1, S_FREE);
      for (int i = 0; i < 3; i++) wr(1, 32'h80, 32'h0, S_BUSY);
      wr(1, 32'h80, 32'h0, S_ACC);
      wr(1, 32'h80, 32'h0, S_BUSY);
      idl(1, S_FREE);
      wr(1, 32'h80, 32'h11111111, S_BUSY);
      wr(1, 32'h80, 32'h11111111, S_BUSY);
      idl(1, S_FREE);                         // abort after 2 BUSY
      for (int i = 0; i < 3; i++) rd(1, 32'h80, S_BUSY);
      rdl(1, 32'h80, S_ACC, 32'h0);
      idl(1, S_FREE);

      // Scenario 4 (LAT2): illegal requests go to ERROR and never write; ramload holds.
      for (int i = 0; i < 2; i++) wr(0, 32'h10, 32'h0BADF00D, S_BUSY);
      vecs.push_back(mk(0, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, S_ACC, 1'b1, 32'h12345678));
      wr(0, 32'h10, 32'h0BADF00D, S_BUSY);
      idl(0, S_FREE);
      vecs.push_back(mk(0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, S_ERR, 1'b1, 32'h12345678));
      vecs.push_back(mk(0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, S_ERR, 1'b1, 32'h12345678));
      idl(0, S_FREE);
      rd(0, 32'h3, S_ERR);
      rd(0, 32'h3, S_ERR);
      idl(0, S_FREE);
      rd(0, 32'h10000, S_ERR);
      idl(0, S_FREE);
      rd(0, 32'h10, S_BUSY);
      rd(0, 32'h10, S_BUSY);
      rdl(0, 32'h10, S_ACC, 32'h0BADF00D);
      idl(0, S_FREE);

      // Scenario 5 (LAT0): preload 0x0 and 0x4, then back-to-back reads.
      wr(2, 32'h0, 32'hAAAA0000, S_ACC);
      wr(2, 32'h0, 32'hAAAA0000, S_ACC);
      idl(2, S_FREE);
      wr(2, 32'h4, 32'hBBBB0004, S_ACC);
      wr(2, 32'h4, 32'hBBBB0004, S_ACC);
      idl(2, S_FREE);
      rdl(2, 32'h0, S_ACC, 32'hAAAA0000);
      rdl(2, 32'h4, S_ACC, 32'hBBBB0004);
      idl(2, S_FREE);

      // Preload 0x20 (LAT2) for the reset scenario.
      for (int i = 0; i < 2; i++) wr(0, 32'h20, 32'h20202020, S_BUSY);
      wr(0, 32'h20, 32'h20202020, S_ACC);
      wr(0, 32'h20, 32'h20202020, S_BUSY);
      idl(0, S_FREE);

      // Power-on reset and reset-state checks.
      #1 rst = 1'b1;
      #2;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_state_%0d", i), 32'(state_a[i]), 32'(S_FREE));
         chk($sformatf("reset_load_%0d", i), load_a[i], 32'd0);
      end
`ifdef RAM_STATS_EN
      chk("reset_rd_count", rdc_a[0], 32'd0);
      chk("reset_wr_count", wrc_a[0], 32'd0);
`endif
      tick();
      rst = 1'b0;

      for (int i = 0; i < n1; i++) apply_vec(i, vecs[i]);
`ifdef RAM_STATS_EN
      chk("s1_rd_count", rdc_a[0], 32'd1);
      chk("s1_wr_count", wrc_a[0], 32'd1);
`endif
      for (int i = n1; i < vecs.size(); i++) apply_vec(i, vecs[i]);

      // Async reset in the middle of a BUSY write to 0x20.
      wen_a[0] = 1'b1; addr_a[0] = 32'h20; store_a[0] = 32'hFFFF0000;
      tick();
      chk("rst_pre_busy", 32'(state_a[0]), 32'(S_BUSY));
      chk("rst_pre_load", load_a[0], 32'h0BADF00D);
      #3 rst = 1'b1;
      #1;
      chk("rst_async_state", 32'(state_a[0]), 32'(S_FREE));
      chk("rst_async_load", load_a[0], 32'd0);
`ifdef RAM_STATS_EN
      chk("rst_async_wr_count", wrc_a[0], 32'd0);
      chk("rst_async_rd_count", rdc_a[0], 32'd0);
`endif
      wen_a[0] = 1'b0;
      tick();
      rst = 1'b0;
      apply_vec(1000, mk(0, 1'b1, 1'b0, 32'h20, 32'd0, S_BUSY, 1'b0, 32'd0));
      apply_vec(1001, mk(0, 1'b1, 1'b0, 32'h20, 32'd0, S_BUSY, 1'b0, 32'd0));
      apply_vec(1002, mk(0, 1'b1, 1'b0, 32'h20, 32'd0, S_ACC, 1'b1, 32'h20202020));
      apply_vec(1003, mk(0, 1'b0, 1'b0, 32'h0, 32'd0, S_FREE, 1'b0, 32'd0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
